pp_accum_seq: RTL and testbench

//  Sequential reduction stage directly downstream of the 8x8 partial-product generator.

---
 rtl/pp_pkg.sv | 24 ++
 rtl/pp_accum_seq_if.sv | 36 +++
 rtl/pp_row_align.sv | 22 ++
 rtl/pp_accum_seq.sv | 136 +++++++++++++
 tb/tb_pp_accum_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pp_pkg.sv
// Shared types and constants for the partial-product accumulation stage.
//   PP_N      : number of partial-product rows
//   PROD_W    : product width
//   ROW_IDX_W : width of the row pointer
//   row_w(k)  : bit width of row k (row k spans column weights k..14-k)
//   state_t   : accumulator FSM states
package pp_pkg;

    localparam int unsigned PP_N      = 8;
    localparam int unsigned PROD_W    = 16;
    localparam int unsigned ROW_IDX_W = 3;
    localparam int unsigned ROW0_W    = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int unsigned row_w(input int unsigned k);
        return 15 - 2 * k;
    endfunction

endpackage

// File: rtl/pp_accum_seq_if.sv
// Handshake bundle between the partial-product register, this stage and the consumer.
//   in_valid/in_ready   : row capture handshake
//   pp0..pp7            : rows, row k bit n = column weight n+k
//   out_valid/out_ready : product handshake
//   prod                : 16-bit product
//   busy                : accumulation in progress
// master = producer/consumer side, slave = pp_accum_seq.
interface pp_accum_seq_if;
    import pp_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [row_w(0)-1:0]   pp0;
    logic [row_w(1)-1:0]   pp1;
    logic [row_w(2)-1:0]   pp2;
    logic [row_w(3)-1:0]   pp3;
    logic [row_w(4)-1:0]   pp4;
    logic [row_w(5)-1:0]   pp5;
    logic [row_w(6)-1:0]   pp6;
    logic [row_w(7)-1:0]   pp7;
    logic                  out_valid;
    logic                  out_ready;
    logic [PROD_W-1:0]     prod;
    logic                  busy;

    modport master (
        output in_valid, pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, out_ready,
        input  in_ready, out_valid, prod, busy
    );

    modport slave (
        input  in_valid, pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, out_ready,
        output in_ready, out_valid, prod, busy
    );

endinterface

// File: rtl/pp_row_align.sv
// Aligns one captured row to its column weight (row << k) and optionally
// discards columns below TRUNC_COLS for the approximate build.
//   row       : captured row, zero-extended to 15 bits
//   k         : row index (column weight of bit 0)
//   aligned_c : 16-bit weighted row, combinational
module pp_row_align
    import pp_pkg::*;
#(
    parameter bit          TRUNC_EN   = 1'b0,
    parameter int unsigned TRUNC_COLS = 4
) (
    input  logic [ROW0_W-1:0]    row,
    input  logic [ROW_IDX_W-1:0] k,
    output logic [PROD_W-1:0]    aligned_c
);

    localparam logic [PROD_W-1:0] KEEP_MASK =
        TRUNC_EN ? (16'hFFFF << TRUNC_COLS) : 16'hFFFF;

    assign aligned_c = (PROD_W'(row) << k) & KEEP_MASK;

endmodule

// File: rtl/pp_accum_seq.sv
// Sequential reduction of eight partial-product rows into a 16-bit product,
// ROWS_PER_CYC rows per cycle, with valid/ready on both sides.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pp_accum_seq_if.slave (rows in, product out, busy)
// Build option: define APPROX_TRUNC_EN to drop column weights below TRUNC_COLS.
module pp_accum_seq
    import pp_pkg::*;
#(
    parameter int unsigned ROWS_PER_CYC = 1,
    parameter int unsigned TRUNC_COLS   = 4
) (
    input  logic          clk,
    input  logic          rst,
    pp_accum_seq_if.slave bus
);

`ifdef APPROX_TRUNC_EN
    localparam bit TRUNC_EN = 1'b1;
`else
    localparam bit TRUNC_EN = 1'b0;
`endif

    localparam logic [ROW_IDX_W-1:0] LAST_IDX = ROW_IDX_W'(PP_N - ROWS_PER_CYC);
    localparam logic [ROW_IDX_W-1:0] IDX_STEP = ROW_IDX_W'(ROWS_PER_CYC);

    state_t                 state, state_nx;
    logic [PROD_W-1:0]      acc, acc_nx;
    logic [PROD_W-1:0]      prod_q, prod_nx;
    logic [ROW_IDX_W-1:0]   row_idx, row_idx_nx;
    logic [ROW0_W-1:0]      rows_q [PP_N];
    logic [PROD_W-1:0]      lane_row [ROWS_PER_CYC];
    logic [PROD_W-1:0]      lane_sum;
    logic                   in_ready_c;
    logic                   capture;

    // Ready is combinational on out_ready so HOLD can hand off back-to-back.
    assign in_ready_c    = (state == IDLE) || ((state == HOLD) && bus.out_ready);
    assign capture       = in_ready_c && bus.in_valid;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == HOLD);
    assign bus.busy      = (state == ACC);
    assign bus.prod      = prod_q;

    // One alignment lane per row consumed this cycle; row_idx is always a multiple of R.
    for (genvar l = 0; l < ROWS_PER_CYC; l++) begin : g_lane
        logic [ROW_IDX_W-1:0] idx;
        assign idx = row_idx + ROW_IDX_W'(l);
        pp_row_align #(
            .TRUNC_EN   (TRUNC_EN),
            .TRUNC_COLS (TRUNC_COLS)
        ) u_align (
            .row       (rows_q[idx]),
            .k         (idx),
            .aligned_c (lane_row[l])
        );
    end

    // Sum of the active lanes.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < ROWS_PER_CYC; l++) begin
            lane_sum = lane_sum + lane_row[l];
        end
    end

    // Next-state, accumulator and result update.
    always_comb begin
        state_nx   = state;
        acc_nx     = acc;
        row_idx_nx = row_idx;
        prod_nx    = prod_q;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    state_nx   = ACC;
                    acc_nx     = '0;
                    row_idx_nx = '0;
                end
            end
            ACC: begin
                acc_nx     = acc + lane_sum;
                row_idx_nx = row_idx + IDX_STEP;
                if (row_idx == LAST_IDX) begin
                    state_nx = HOLD;
                    prod_nx  = acc + lane_sum;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        state_nx   = ACC;
                        acc_nx     = '0;
                        row_idx_nx = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            prod_q  <= '0;
            row_idx <= '0;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            prod_q  <= prod_nx;
            row_idx <= row_idx_nx;
        end
    end

    // Row capture, zero-extended to a common width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < PP_N; r++) begin
                rows_q[r] <= '0;
            end
        end else if (capture) begin
            rows_q[0] <= bus.pp0;
            rows_q[1] <= ROW0_W'(bus.pp1);
            rows_q[2] <= ROW0_W'(bus.pp2);
            rows_q[3] <= ROW0_W'(bus.pp3);
            rows_q[4] <= ROW0_W'(bus.pp4);
            rows_q[5] <= ROW0_W'(bus.pp5);
            rows_q[6] <= ROW0_W'(bus.pp6);
            rows_q[7] <= ROW0_W'(bus.pp7);
        end
    end

endmodule

// File: tb/tb_pp_accum_seq.sv
// Directed bench: four instances (R = 1, 2, 4, 8) driven with shared stimulus.
module tb_pp_accum_seq;

    typedef struct packed {
        logic [14:0] r0;
        logic [12:0] r1;
        logic [10:0] r2;
        logic [8:0]  r3;
        logic [6:0]  r4;
        logic [4:0]  r5;
        logic [2:0]  r6;
        logic [0:0]  r7;
    } rows_t;

    typedef struct packed {
        rows_t       rows;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    rows_t       rows_drv;
    logic [3:0]  ov;
    logic [3:0]  ir;
    logic [3:0]  bz;
    logic [15:0] pr [4];

    int checks = 0;
    int errors = 0;
    vec_t vecs [NV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        pp_accum_seq_if u_if ();
        assign u_if.in_valid  = in_valid;
        assign u_if.out_ready = out_ready;
        assign u_if.pp0 = rows_drv.r0;
        assign u_if.pp1 = rows_drv.r1;
        assign u_if.pp2 = rows_drv.r2;
        assign u_if.pp3 = rows_drv.r3;
        assign u_if.pp4 = rows_drv.r4;
        assign u_if.pp5 = rows_drv.r5;
        assign u_if.pp6 = rows_drv.r6;
        assign u_if.pp7 = rows_drv.r7;
        pp_accum_seq #(
            .ROWS_PER_CYC (1 << g),
            .TRUNC_COLS   (4)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if.slave)
        );
        assign ov[g] = u_if.out_valid;
        assign ir[g] = u_if.in_ready;
        assign bz[g] = u_if.busy;
        assign pr[g] = u_if.prod;
    end

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s R=%0d: got %0h expected %0h at %0t", name, 1 << g, act, exp, $time);
        end
    endtask

    function automatic rows_t mk(input logic [14:0] a0, input logic [12:0] a1, input logic [10:0] a2,
                                 input logic [8:0] a3, input logic [6:0] a4, input logic [4:0] a5,
                                 input logic [2:0] a6, input logic [0:0] a7);
        rows_t r;
        r.r0 = a0; r.r1 = a1; r.r2 = a2; r.r3 = a3;
        r.r4 = a4; r.r5 = a5; r.r6 = a6; r.r7 = a7;
        return r;
    endfunction

    // Present rows with in_valid while all instances are idle; capture on next edge.
    task automatic start_txn(input rows_t rows);
        rows_drv = rows;
        in_valid = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) chk("in_ready_idle", g, 32'(ir[g]), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int g = 0; g < 4; g++) begin
            chk("busy_after_capture", g, 32'(bz[g]), 32'd1);
            chk("no_valid_after_capture", g, 32'(ov[g]), 32'd0);
        end
    endtask

    // Wait up to 8 edges; each instance must raise out_valid exactly 8/R edges after capture.
    task automatic finish_txn(input logic [15:0] exp, input string name);
        int lat [4];
        for (int g = 0; g < 4; g++) lat[g] = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) begin
                if (ov[g] && lat[g] == 0) lat[g] = k;
            end
        end
        for (int g = 0; g < 4; g++) begin
            chk({name, "_latency"}, g, 32'(lat[g]), 32'(8 >> g));
            chk({name, "_prod"}, g, 32'(pr[g]), 32'(exp));
        end
    endtask

    // Consumer takes the result; everyone returns to IDLE.
    task automatic release_txn();
        out_ready = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) chk("in_ready_hold_ready", g, 32'(ir[g]), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            chk("valid_cleared", g, 32'(ov[g]), 32'd0);
            chk("idle_not_busy", g, 32'(bz[g]), 32'd0);
        end
    endtask

    initial begin
        // {rows, expected product}; approximate build drops weights < 4 per row.
`ifdef APPROX_TRUNC_EN
        vecs[0] = '{rows: mk(15'h7FFF, 13'h1FFF, 11'h7FF, 9'h1FF, 7'h7F, 5'h1F, 3'h7, 1'h1), exp: 16'hFDD0};
        vecs[1] = '{rows: mk(15'h00AC, 13'h0800, 11'h000, 9'h1C0, 7'h60, 5'h10, 3'h0, 1'h0), exp: 16'h26A0};
        vecs[2] = '{rows: mk(15'h0000, 13'h0000, 11'h000, 9'h000, 7'h00, 5'h00, 3'h0, 1'h0), exp: 16'h0000};
        vecs[3] = '{rows: mk(15'h0000, 13'h0000, 11'h000, 9'h000, 7'h00, 5'h00, 3'h0, 1'h1), exp: 16'h0080};
        vecs[4] = '{rows: mk(15'h0000, 13'h0000, 11'h7FF, 9'h000, 7'h00, 5'h00, 3'h5, 1'h0), exp: 16'h2130};
        vecs[5] = '{rows: mk(15'h0000, 13'h1FFF, 11'h000, 9'h000, 7'h00, 5'h00, 3'h0, 1'h0), exp: 16'h3FF0};
        vecs[6] = '{rows: mk(15'h0001, 13'h0000, 11'h000, 9'h000, 7'h00, 5'h00, 3'h0, 1'h1), exp: 16'h0080};
        vecs[7] = '{rows: mk(15'h0000, 13'h0000, 11'h000, 9'h1FF, 7'h7F, 5'h00, 3'h0, 1'h0), exp: 16'h17E0};
`else
        vecs[0] = '{rows: mk(15'h7FFF, 13'h1FFF, 11'h7FF, 9'h1FF, 7'h7F, 5'h1F, 3'h7, 1'h1), exp: 16'hFE01};
        vecs[1] = '{rows: mk(15'h00AC, 13'h0800, 11'h000, 9'h1C0, 7'h60, 5'h10, 3'h0, 1'h0), exp: 16'h26AC};
        vecs[2] = '{rows: mk(15'h0000, 13'h0000, 11'h000, 9'h000, 7'h00, 5'h00, 3'h0, 1'h0), exp: 16'h0000};
        vecs[3] = '{rows: mk(15'h0000, 13'h0000, 11'h000, 9'h000, 7'h00, 5'h00, 3'h0, 1'h1), exp: 16'h0080};
        vecs[4] = '{rows: mk(15'h0000, 13'h0000, 11'h7FF, 9'h000, 7'h00, 5'h00, 3'h5, 1'h0), exp: 16'h213C};
        vecs[5] = '{rows: mk(15'h0000, 13'h1FFF, 11'h000, 9'h000, 7'h00, 5'h00, 3'h0, 1'h0), exp: 16'h3FFE};
        vecs[6] = '{rows: mk(15'h0001, 13'h0000, 11'h000, 9'h000, 7'h00, 5'h00, 3'h0, 1'h1), exp: 16'h0081};
        vecs[7] = '{rows: mk(15'h0000, 13'h0000, 11'h000, 9'h1FF, 7'h7F, 5'h00, 3'h0, 1'h0), exp: 16'h17E8};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rows_drv  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("reset_out_valid", g, 32'(ov[g]), 32'd0);
            chk("reset_busy", g, 32'(bz[g]), 32'd0);
            chk("reset_prod", g, 32'(pr[g]), 32'd0);
            chk("reset_in_ready", g, 32'(ir[g]), 32'd1);
        end
        @(posedge clk);
        #1;

        // Table-driven products.
        for (int i = 0; i < NV; i++) begin
            start_txn(vecs[i].rows);
            finish_txn(vecs[i].exp, $sformatf("vec%0d", i));
            release_txn();
        end

        // Back-pressure in HOLD, then back-to-back capture.
        start_txn(vecs[0].rows);
        finish_txn(vecs[0].exp, "bp_first");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) begin
                chk("bp_valid_held", g, 32'(ov[g]), 32'd1);
                chk("bp_prod_held", g, 32'(pr[g]), 32'(vecs[0].exp));
                chk("bp_in_ready_low", g, 32'(ir[g]), 32'd0);
            end
        end
        rows_drv  = vecs[1].rows;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) chk("b2b_in_ready", g, 32'(ir[g]), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            chk("b2b_busy", g, 32'(bz[g]), 32'd1);
            chk("b2b_valid_low", g, 32'(ov[g]), 32'd0);
        end
        finish_txn(vecs[1].exp, "b2b_second");
        release_txn();

        // Reset three cycles into ACC: no product may surface.
        start_txn(vecs[0].rows);
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) chk("pre_reset_busy", g, 32'(bz[g]), 32'd1);
        rst = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("midrst_valid", g, 32'(ov[g]), 32'd0);
            chk("midrst_busy", g, 32'(bz[g]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) chk("postrst_no_valid", g, 32'(ov[g]), 32'd0);
        end
        for (int g = 0; g < 4; g++) chk("postrst_prod", g, 32'(pr[g]), 32'd0);
        start_txn(vecs[4].rows);
        finish_txn(vecs[4].exp, "postrst_txn");
        release_txn();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
